// File: rtl/mult_div_sequencer_pkg.sv
// rtl/mult_div_sequencer_pkg.sv - shared encodings for the multiply/divide sequencer
// Lets the control unit drive op symbolically and keeps state encoding in one place.
package mult_div_sequencer_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_CNT_W = 6;

   typedef enum logic {
      OP_MULT = 1'b0,
      OP_DIV  = 1'b1
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MULT_RUN = 2'd1,
      ST_DIV_RUN  = 2'd2,
      ST_FINISH   = 2'd3
   } state_t;

endpackage

// File: rtl/mult_div_sequencer_div_step.sv
// rtl/mult_div_sequencer_div_step.sv - one combinational restoring-divide iteration
// Operates on magnitudes; the sequencer applies signs after the last step.
module mult_div_sequencer_div_step
   import mult_div_sequencer_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic [WIDTH-1:0] i_quo,
   input  logic [WIDTH-1:0] i_dvsr,
   output logic [WIDTH-1:0] o_rem,
   output logic [WIDTH-1:0] o_quo
);

   logic [WIDTH:0] w_shift;
   logic [WIDTH:0] w_diff;

   // One extra bit so a shifted remainder up to 2*divisor-1 never overflows.
   assign w_shift = {i_rem, i_quo[WIDTH-1]};
   assign w_diff  = w_shift - {1'b0, i_dvsr};

   assign o_rem = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
   assign o_quo = {i_quo[WIDTH-2:0], ~w_diff[WIDTH]};

endmodule

// File: rtl/mult_div_sequencer.sv
// rtl/mult_div_sequencer.sv - iterative signed MULT/DIV unit writing the HI/LO pair
// Radix-2 Booth multiply and restoring divide, one bit per clock.
module mult_div_sequencer
   import mult_div_sequencer_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic             i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_div_zero,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   localparam int               PW      = 2 * WIDTH + 2;
   localparam logic [CNT_W-1:0] CNT_FIX = CNT_W'(WIDTH);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [PW-1:0]    r_prod;
   logic [WIDTH:0]   r_mcand;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_dvsr;
   logic             r_sign_q;
   logic             r_sign_r;

   logic [WIDTH:0]   w_acc;
   logic [PW-1:0]    w_prod_next;
   logic [WIDTH-1:0] w_rem_next;
   logic [WIDTH-1:0] w_quo_next;
   logic [WIDTH-1:0] w_abs_a;
   logic [WIDTH-1:0] w_abs_b;
   logic [WIDTH-1:0] w_quo_fix;
   logic [WIDTH-1:0] w_rem_fix;

   // Accumulator is WIDTH+1 bits so subtracting MIN_INT cannot overflow.
   always_comb begin
      w_acc = r_prod[PW-1:WIDTH+1];
      case (r_prod[1:0])
         2'b01:   w_acc = r_prod[PW-1:WIDTH+1] + r_mcand;
         2'b10:   w_acc = r_prod[PW-1:WIDTH+1] - r_mcand;
         default: w_acc = r_prod[PW-1:WIDTH+1];
      endcase
      w_prod_next = {w_acc[WIDTH], w_acc, r_prod[WIDTH:1]};
   end

   assign w_abs_a   = i_a[WIDTH-1] ? (~i_a + ONE) : i_a;
   assign w_abs_b   = i_b[WIDTH-1] ? (~i_b + ONE) : i_b;
   assign w_quo_fix = r_sign_q ? (~r_quo + ONE) : r_quo;
   assign w_rem_fix = r_sign_r ? (~r_rem + ONE) : r_rem;

   mult_div_sequencer_div_step #(
      .WIDTH (WIDTH)
   ) u_div_step (
      .i_rem  (r_rem),
      .i_quo  (r_quo),
      .i_dvsr (r_dvsr),
      .o_rem  (w_rem_next),
      .o_quo  (w_quo_next)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_prod     <= '0;
         r_mcand    <= '0;
         r_rem      <= '0;
         r_quo      <= '0;
         r_dvsr     <= '0;
         r_sign_q   <= 1'b0;
         r_sign_r   <= 1'b0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
         o_div_zero <= 1'b0;
         o_hi       <= '0;
         o_lo       <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_cnt <= '0;
                  if (op_t'(i_op) == OP_MULT) begin
                     r_mcand <= {i_a[WIDTH-1], i_a};
                     r_prod  <= {{(WIDTH + 1){1'b0}}, i_b, 1'b0};
                     r_state <= ST_MULT_RUN;
                     o_busy  <= 1'b1;
                  end else if (i_b == '0) begin
                     r_state    <= ST_FINISH;
                     o_done     <= 1'b1;
                     o_div_zero <= 1'b1;
                  end else begin
                     r_rem    <= '0;
                     r_quo    <= w_abs_a;
                     r_dvsr   <= w_abs_b;
                     r_sign_q <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
                     r_sign_r <= i_a[WIDTH-1];
                     r_state  <= ST_DIV_RUN;
                     o_busy   <= 1'b1;
                  end
               end
            end

            // Steps run while r_cnt counts 0..WIDTH-1; the edge after the
            // terminal step commits the result and enters FINISH.
            ST_MULT_RUN: begin
               if (r_cnt == CNT_FIX) begin
                  o_hi    <= r_prod[2*WIDTH:WIDTH+1];
                  o_lo    <= r_prod[WIDTH:1];
                  o_busy  <= 1'b0;
                  o_done  <= 1'b1;
                  r_state <= ST_FINISH;
               end else begin
                  r_prod <= w_prod_next;
                  r_cnt  <= r_cnt + 1'b1;
               end
            end

            ST_DIV_RUN: begin
               if (r_cnt == CNT_FIX) begin
                  o_hi    <= w_rem_fix;
                  o_lo    <= w_quo_fix;
                  o_busy  <= 1'b0;
                  o_done  <= 1'b1;
                  r_state <= ST_FINISH;
               end else begin
                  r_rem <= w_rem_next;
                  r_quo <= w_quo_next;
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            ST_FINISH: begin
               o_done     <= 1'b0;
               o_div_zero <= 1'b0;
               r_cnt      <= '0;
               r_state    <= ST_IDLE;
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_sequencer.sv
// tb/tb_mult_div_sequencer.sv - scoreboard bench for the multiply/divide sequencer
// Expected HI/LO come from 64-bit signed arithmetic on the operands.
module tb_mult_div_sequencer;
   import mult_div_sequencer_pkg::*;

   localparam int W  = 32;
   localparam int CW = 6;

   logic         clk = 1'b0;
   logic         i_reset;
   logic         i_start;
   logic         i_op;
   logic [W-1:0] i_a;
   logic [W-1:0] i_b;
   logic         o_busy;
   logic         o_done;
   logic         o_div_zero;
   logic [W-1:0] o_hi;
   logic [W-1:0] o_lo;

   mult_div_sequencer #(
      .WIDTH (W),
      .CNT_W (CW)
   ) dut (
      .i_clk      (clk),
      .i_reset    (i_reset),
      .i_start    (i_start),
      .i_op       (i_op),
      .i_a        (i_a),
      .i_b        (i_b),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_div_zero (o_div_zero),
      .o_hi       (o_hi),
      .o_lo       (o_lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
      int           due;
      int           busy_len;
   } exp_t;

   exp_t         sb[$];
   exp_t         mon_e;
   int           errors   = 0;
   int           checks   = 0;
   int           cyc      = 0;
   int           busy_run = 0;
   int           n_done   = 0;
   int           n_issued = 0;
   logic [W-1:0] m_hi     = '0;
   logic [W-1:0] m_lo     = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops one expectation per done pulse.
   always @(negedge clk) begin
      if (i_reset) begin
         busy_run = 0;
      end else begin
         if (o_busy) busy_run++;
         if (o_div_zero) check("dz_only_with_done", o_done, 1);
         if (o_done) begin
            n_done++;
            check("expectation_pending", sb.size() > 0, 1);
            if (sb.size() > 0) begin
               mon_e = sb.pop_front();
               check("hi", o_hi, mon_e.hi);
               check("lo", o_lo, mon_e.lo);
               check("div_zero", o_div_zero, mon_e.dz);
               check("done_latency", cyc, mon_e.due);
               check("busy_cycles", busy_run, mon_e.busy_len);
               check("busy_low_at_done", o_busy, 0);
            end
            busy_run = 0;
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while ((o_busy || o_done) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: busy=%0b done=%0b after %0d cycles", o_busy, o_done, n);
      end
   endtask

   task automatic issue(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t   e;
      longint sa;
      longint sbv;
      longint p;
      longint q;
      longint r;
      wait_idle();
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      if (op == OP_MULT) begin
         p          = sa * sbv;
         m_hi       = p[2*W-1:W];
         m_lo       = p[W-1:0];
         e.dz       = 1'b0;
         e.due      = cyc + W + 2;
         e.busy_len = W + 1;
      end else if (b == '0) begin
         e.dz       = 1'b1;
         e.due      = cyc + 1;
         e.busy_len = 0;
      end else begin
         q          = sa / sbv;
         r          = sa % sbv;
         m_hi       = r[W-1:0];
         m_lo       = q[W-1:0];
         e.dz       = 1'b0;
         e.due      = cyc + W + 2;
         e.busy_len = W + 1;
      end
      e.hi = m_hi;
      e.lo = m_lo;
      sb.push_back(e);
      n_issued++;
      i_start = 1'b1;
      i_op    = op;
      i_a     = a;
      i_b     = b;
      @(posedge clk);
      #1;
      i_start = 1'b0;
      i_op    = 1'($urandom);
      i_a     = $urandom;
      i_b     = $urandom;
   endtask

   function automatic logic [W-1:0] pick_operand();
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
         0:       return '0;
         1:       return {W{1'b1}};
         2:       return {1'b1, {(W-1){1'b0}}};
         3:       return W'($urandom_range(1, 20));
         4:       return W'(-$urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      i_reset = 1'b1;
      i_start = 1'b0;
      i_op    = 1'b0;
      i_a     = '0;
      i_b     = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", o_busy, 0);
      check("reset_done", o_done, 0);
      check("reset_div_zero", o_div_zero, 0);
      check("reset_hi", o_hi, 0);
      check("reset_lo", o_lo, 0);
      i_reset = 1'b0;
      @(posedge clk);
      #1;

      issue(OP_MULT, 32'h0000_0007, 32'hFFFF_FFFD);
      issue(OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002);
      issue(OP_DIV,  32'h1234_5678, 32'h7FFF_FFFF);
      issue(OP_DIV,  32'h0000_0005, 32'h0000_0000);

      // Second request during a MULT must be dropped.
      issue(OP_MULT, 32'h0001_2345, 32'hFFFE_0001);
      repeat (9) @(posedge clk);
      #1;
      i_start = 1'b1;
      i_op    = OP_DIV;
      i_a     = 32'h0000_0064;
      i_b     = 32'h0000_0003;
      @(posedge clk);
      #1;
      i_start = 1'b0;
      wait_idle();

      // Reset in the middle of a DIV abandons it and clears HI/LO.
      issue(OP_DIV, 32'hFFFE_7960, 32'h0000_0007);
      repeat (16) @(posedge clk);
      #1;
      i_reset = 1'b1;
      sb.delete();
      n_issued--;
      m_hi = '0;
      m_lo = '0;
      @(posedge clk);
      #1;
      check("abort_busy", o_busy, 0);
      check("abort_done", o_done, 0);
      check("abort_hi", o_hi, 0);
      check("abort_lo", o_lo, 0);
      i_reset = 1'b0;
      @(posedge clk);
      #1;
      issue(OP_MULT, 32'h0000_0003, 32'h0000_0004);

      issue(OP_MULT, 32'h8000_0000, 32'h8000_0000);
      issue(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
      issue(OP_DIV,  32'h8000_0000, 32'h0000_0000);

      for (int i = 0; i < 40; i++) begin
         issue(1'($urandom), pick_operand(), pick_operand());
      end

      wait_idle();
      repeat (3) @(posedge clk);
      #1;
      check("done_count", n_done, n_issued);
      check("scoreboard_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
